// File: rtl/spi_cfg_sequencer.sv
// Replays a small {addr,data} table to an SPI shifter, one command per frame,
// with a fixed CS-high gap between frames. Define SPI_SEQ_TIMEOUT_EN for the WAIT timeout.
module spi_cfg_sequencer #(
  parameter int unsigned DEPTH_LOG2     = 4,
  parameter logic [7:0]  GAP_CYCLES     = 8'd8,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tbl_we,
  input  logic [DEPTH_LOG2-1:0] tbl_addr,
  input  logic [23:0]           tbl_wdata,
  input  logic [DEPTH_LOG2:0]   num_entries,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DEPTH_LOG2-1:0] cur_idx,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [23:0]           cmd_data,
  input  logic                  xfer_done
);
  localparam int unsigned         ENTRIES = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] MAX_N   = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE, S_WAIT, S_GAP, S_DONE
  } state_t;

  state_t                state;
  logic [23:0]           tbl [ENTRIES];
  logic [DEPTH_LOG2:0]   n;
  logic [7:0]            gap_cnt;
  logic                  last;
  logic [DEPTH_LOG2-1:0] nxt_idx;

  assign last    = ({1'b0, cur_idx} == n - (DEPTH_LOG2+1)'(1));
  assign nxt_idx = cur_idx + DEPTH_LOG2'(1);

  // Table is only writable while idle so a running sequence sees a stable image.
  always_ff @(posedge clk)
    if (tbl_we && state == S_IDLE) tbl[tbl_addr] <= tbl_wdata;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_hit;
  assign to_hit = (to_cnt == TIMEOUT_CYCLES - 8'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      cur_idx   <= '0;
      n         <= '0;
      gap_cnt   <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      err       <= 1'b0;
      to_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
`ifdef SPI_SEQ_TIMEOUT_EN
          err <= 1'b0;
`endif
          if (num_entries == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            n         <= (num_entries > MAX_N) ? MAX_N : num_entries;
            cur_idx   <= '0;
            busy      <= 1'b1;
            cmd_valid <= 1'b1;
            cmd_data  <= tbl[0];
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: if (cmd_ready) begin
          cmd_valid <= 1'b0;
          state     <= S_WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
          to_cnt    <= '0;
`endif
        end
        S_WAIT: begin
          if (xfer_done) begin
            if (last) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cur_idx <= nxt_idx;
              // A zero gap skips GAP entirely and reissues straight away.
              if (GAP_CYCLES == 8'd0) begin
                cmd_valid <= 1'b1;
                cmd_data  <= tbl[nxt_idx];
                state     <= S_ISSUE;
              end else begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end
            end
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (to_hit) begin
            err   <= 1'b1;
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        S_GAP: begin
          if (gap_cnt == GAP_CYCLES - 8'd1) begin
            cmd_valid <= 1'b1;
            cmd_data  <= tbl[cur_idx];
            state     <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench for spi_cfg_sequencer: expected commands queued at start,
// popped on each cmd handshake; a small shifter model returns xfer_done.
module tb_spi_cfg_sequencer;
  localparam int DL = 4;
  localparam int NE = 1 << DL;

  logic          clk = 1'b0, reset_n = 1'b0, tbl_we = 1'b0, start = 1'b0;
  logic          cmd_ready = 1'b1, xfer_done = 1'b0;
  logic [DL-1:0] tbl_addr = '0;
  logic [23:0]   tbl_wdata = '0;
  logic [DL:0]   num_entries = '0;
  logic          busy, done, err, cmd_valid;
  logic [DL-1:0] cur_idx;
  logic [23:0]   cmd_data;

  int          checks = 0, failures = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_tbl[NE];
  int          n_acc = 0, n_done = 0, cyc = 0, xd_cyc = 0, xfer_cnt = 0;
  bit          auto_xfer = 1'b1, gap_pend = 1'b0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [23:0] pd = '0;
  int          a0, d0, k;

  spi_cfg_sequencer #(.DEPTH_LOG2(DL), .GAP_CYCLES(8'd8), .TIMEOUT_CYCLES(8'd20)) dut (
    .clk(clk), .reset_n(reset_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .num_entries(num_entries), .start(start),
    .busy(busy), .done(done), .err(err), .cur_idx(cur_idx),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .xfer_done(xfer_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int idx, input logic [23:0] d);
    tbl_we = 1'b1; tbl_addr = DL'(idx); tbl_wdata = d;
    tick;
    tbl_we = 1'b0;
  endtask

  task automatic go(input int n);
    tick;
    num_entries = (DL+1)'(n); start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int w;
    w = 0;
    while (!done && w < limit) begin @(negedge clk); w++; end
    chk("done_seen", done, 1);
  endtask

  // Shifter model + scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    xfer_done = 1'b0;
    if (xfer_cnt > 0) begin
      xfer_cnt--;
      if (xfer_cnt == 0) begin
        xfer_done = 1'b1;
        if (busy) begin gap_pend = 1'b1; xd_cyc = cyc; end
      end
    end
    if (!busy) gap_pend = 1'b0;
    if (pv && !pr) begin
      chk("hold_valid", cmd_valid, 1);
      chk("hold_data", cmd_data, pd);
    end
    if (cmd_valid && !pv && gap_pend) begin
      chk("gap", cyc - xd_cyc, 9);
      gap_pend = 1'b0;
    end
    if (cmd_valid && cmd_ready) begin
      n_acc++;
      chk("cmd_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("cmd_data", cmd_data, exp_q.pop_front());
      if (auto_xfer) xfer_cnt = 40;
    end
    if (done) n_done++;
    pv = cmd_valid; pr = cmd_ready; pd = cmd_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NE; i++) exp_tbl[i] = {16'hA000 + 16'(i), 8'(i + 16)};
    exp_tbl[0] = 24'h123401; exp_tbl[1] = 24'hABCD02; exp_tbl[2] = 24'h00FF03;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_idx", cur_idx, 0);
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < NE; i++) wr(i, exp_tbl[i]);

    // three-entry sequence
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_tbl[i]);
    a0 = n_acc; d0 = n_done;
    go(3);
    chk("t1_busy", busy, 1);
    chk("t1_valid", cmd_valid, 1);
    wait_done(400);
    chk("t1_busy_done", busy, 0);
    chk("t1_err", err, 0);
    chk("t1_idx", cur_idx, 2);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_acc", n_acc - a0, 3);
    chk("t1_ndone", n_done - d0, 1);

    // backpressure for 5 cycles
    cmd_ready = 1'b0;
    exp_q.push_back(exp_tbl[0]);
    a0 = n_acc;
    go(1);
    repeat (5) tick;
    chk("t2_valid_held", cmd_valid, 1);
    chk("t2_noacc", n_acc - a0, 0);
    cmd_ready = 1'b1;
    wait_done(200);
    tick;
    chk("t2_acc", n_acc - a0, 1);

    // zero entries
    a0 = n_acc;
    go(0);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_valid", cmd_valid, 0);
    tick;
    chk("t3_done_end", done, 0);
    repeat (3) tick;
    chk("t3_acc", n_acc - a0, 0);

    // oversize request clamps to table depth
    for (int i = 0; i < NE; i++) exp_q.push_back(exp_tbl[i]);
    a0 = n_acc;
    go(31);
    wait_done(2000);
    chk("t4_acc", n_acc - a0, 16);
    chk("t4_idx", cur_idx, 15);
    chk("t4_q", exp_q.size(), 0);
    tick;

    // reset during WAIT of entry 1, after a dropped table write
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_tbl[i]);
    a0 = n_acc;
    go(3);
    k = 0;
    while (n_acc - a0 < 2 && k < 500) begin @(negedge clk); k++; end
    chk("t5_reach_e1", n_acc - a0, 2);
    tick;
    tbl_we = 1'b1; tbl_addr = '0; tbl_wdata = 24'hDEAD00;
    tick;
    tbl_we = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", cmd_valid, 0);
    chk("t5_data", cmd_data, 0);
    chk("t5_idx", cur_idx, 0);
    chk("t5_done", done, 0);
    chk("t5_q_left", exp_q.size(), 1);
    exp_q.delete();
    tick;
    reset_n = 1'b1;
    repeat (45) tick;
    chk("t5_idle", busy, 0);
    exp_q.push_back(exp_tbl[0]);
    a0 = n_acc;
    go(1);
    wait_done(200);
    chk("t5_acc", n_acc - a0, 1);
    tick;

    // withheld xfer_done on entry 0 of two
    auto_xfer = 1'b0;
    exp_q.push_back(exp_tbl[0]);
    a0 = n_acc; d0 = n_done;
    go(2);
`ifdef SPI_SEQ_TIMEOUT_EN
    wait_done(100);
    chk("t6_err", err, 1);
    chk("t6_busy", busy, 0);
    tick;
    chk("t6_acc", n_acc - a0, 1);
    chk("t6_err_sticky", err, 1);
    auto_xfer = 1'b1;
    exp_q.push_back(exp_tbl[0]);
    go(1);
    chk("t6_err_clr", err, 0);
    wait_done(200);
    tick;
`else
    repeat (100) tick;
    chk("t6_busy", busy, 1);
    chk("t6_err", err, 0);
    chk("t6_idx", cur_idx, 0);
    chk("t6_acc", n_acc - a0, 1);
    chk("t6_nodone", n_done - d0, 0);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
`endif
    chk("end_q", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
